// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode boundary of the MIPS pipeline.
package fetch_pkg;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One fetched instruction together with its address.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_decode_queue_wrap_ctr.sv
// Pointer counter modulo DEPTH (power of two) with increment enable and
// synchronous clear; used for the queue's read and write pointers.
module wrap_ctr
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] value
);

  logic [AW-1:0] value_r;

  // Advance the pointer; DEPTH is a power of two so the natural overflow
  // of the AW-bit register is the wrap from DEPTH-1 back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= {AW{1'b0}};
    end else if (clr) begin
      value_r <= {AW{1'b0}};
    end else if (inc) begin
      value_r <= value_r + AW'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule : wrap_ctr

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Buffers {PC, instruction}
// pairs so a decode stall does not immediately back-pressure fetch; a flush
// (branch/jump redirect) empties the queue in one cycle.
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [PC_W-1:0]          out_next_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]      FULL_COUNT = CW'(DEPTH);
  localparam logic [PC_W-1:0]    PC_STEP    = PC_W'(PC_INC);
  localparam logic [INSTR_W-1:0] EMPTY_INSTR = INSTR_W'(NOP_INSTR);

  logic [PC_W-1:0]    pc_mem_r    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [CW-1:0]      count_r;
  logic [AW-1:0]      wr_ptr_s;
  logic [AW-1:0]      rd_ptr_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;

  // Ready/valid come only from the occupancy register: a full queue
  // refuses a push even when decode pops in the same cycle.
  assign full_s    = (count_r == FULL_COUNT);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign push_s    = in_valid && !full_s && !flush && !reset;
  assign pop_s     = !empty_s && out_ready && !flush && !reset;
  assign count     = count_r;

  wrap_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (push_s),
    .value (wr_ptr_s)
  );

  wrap_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (pop_s),
    .value (rd_ptr_s)
  );

  // Write an accepted entry into the slot at the write pointer; storage is
  // never cleared because the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_s]    <= in_pc;
      instr_mem_r[wr_ptr_s] <= in_instr;
    end
  end

  // Occupancy counter: reset and flush empty the queue, a simultaneous
  // push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Present the head entry, forced to zero while the queue is empty so
  // stale storage never leaks to decode.
  always_comb begin
    out_pc    = {PC_W{1'b0}};
    out_instr = EMPTY_INSTR;
    if (!empty_s) begin
      out_pc    = pc_mem_r[rd_ptr_s];
      out_instr = instr_mem_r[rd_ptr_s];
    end else begin
      out_pc    = {PC_W{1'b0}};
      out_instr = EMPTY_INSTR;
    end
  end

  // Sequential successor address, wrapping modulo 2^PC_W.
  assign out_next_pc = out_pc + PC_STEP;

endmodule : fetch_decode_queue

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Small instruction queue between the fetch stage and decode in the MIPS pipeline. Accepts one `{PC, instruction}` pair per cycle from the fetch stage's outputs (`PC`, `instructions`) and presents them in order to decode with a valid/ready handshake, so a decode stall does not immediately stall fetch. A flush, driven on branch/jump redirect, discards all queued entries in one cycle.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `PC_W`, 9, PC width (matches `PCWidth`)
- `INSTR_W`, 32, instruction width (matches `valWidth`)
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  discard all entries at next edge
- `in_valid`  in  1  fetch presents an entry
- `in_ready`  out  1  queue can accept this cycle
- `in_pc`  in  PC_W  PC of fetched instruction
- `in_instr`  in  INSTR_W  fetched instruction word
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  decode consumes head this cycle
- `out_pc`  out  PC_W  head PC
- `out_instr`  out  INSTR_W  head instruction
- `out_next_pc`  out  PC_W  `out_pc + 4`, modulo 2^PC_W
- `count`  out  clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer; write pointer, read pointer, occupancy counter.
- Push when `in_valid && in_ready && !flush`; pop when `out_valid && out_ready && !flush`.
- `in_ready = (count != DEPTH)`; purely from registered state, no dependence on `out_ready` (no pass-through when full).
- `out_valid = (count != 0)`; `out_pc`/`out_instr` are the head entry when valid, forced to 0 when empty.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap from DEPTH-1 to 0.
- `flush`: at next edge count=0, both pointers=0; any push/pop in that cycle is ignored. Storage contents need not be cleared.
- Priority: `reset` > `flush` > push/pop.
- `out_next_pc` wraps: `out_pc` = 508 gives 0 (PC_W=9). When empty, it is 4.
- No state machine beyond the occupancy counter; states are EMPTY (count=0), PARTIAL, FULL (count=DEPTH).

## Timing
- Reset: `count`=0, pointers=0, `out_valid`=0, `out_pc`=0, `out_instr`=0, `out_next_pc`=4, `in_ready`=1.
- Latency: an entry pushed at edge N is visible on `out_*` after edge N (one cycle); no same-cycle bypass while empty.
- All outputs derive from registers through combinational logic only; none depends combinationally on `in_*` or `out_ready`.
- Throughput: 1 entry/cycle sustained when `out_ready` is held high.
- Reset or flush asserted mid-stream: takes effect at the same edge; the following cycle shows EMPTY state.

## Structure
- Shared package `fetch_pkg`: `PC_W`=9, `INSTR_W`=32, `PC_INC`=4, `NOP_INSTR`=32'h0000_0000, typedef `fetch_entry_t` = `{pc, instr}`.
- One sub-module: `wrap_ctr`, a pointer counter modulo DEPTH with increment enable and synchronous clear. It is instantiated for the read and write pointers.
- Storage array, occupancy counter and output muxing live in the top module.

## Test plan
- Reset, then idle: `out_valid`=0, `in_ready`=1, `count`=0, `out_pc`=0, `out_next_pc`=4.
- Push PC 0,4,8,12 (instr 0x20010001..04) with `out_ready`=0: `count` reaches 4, `in_ready`=0, and a 5th push (PC 16) is refused. Then with `out_ready`=1 the entries drain in order 0,4,8,12.
- Stream 16 entries with both sides always ready: one pop per cycle, `count` stays 1, and pointer wrap is exercised.
- Queue holds 3 entries and `flush`=1 together with `in_valid`=1 (PC 100) and `out_ready`=1: the next cycle has `count`=0 and `out_valid`=0, and PC 100 is never output.
- Push PC 508: `out_next_pc`=0.
- Full queue with push and pop requested in the same cycle: the pop happens, the push is refused (`in_ready`=0), and `count` goes to 3. `reset` asserted mid-stream empties the queue at the next edge.
